// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the commit-record type for the write-back register file.
// All of these are derived from the RV64 integer register file geometry.
package wb_regfile_pkg;

  localparam int XLEN    = 64;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  localparam logic [XLEN-1:0]   ZERO_WORD = '0;
  localparam logic [XLEN-1:0]   ONE_WORD  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } commit_rec_t;

endpackage

// File: rtl/wb_regfile.sv
// Write-back stage: commits results to the 32x64 integer register file.
// It also serves ID reads with WB->ID bypass and keeps the instret counter and commit record.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic [XLEN-1:0]   rd_wdata_i,
  input  logic [ADDR_W-1:0] rd_waddr_i,
  input  logic              reg_wen_i,
  input  logic [ADDR_W-1:0] rs1_raddr_i,
  input  logic [ADDR_W-1:0] rs2_raddr_i,
  output logic [XLEN-1:0]   rs1_rdata_o,
  output logic [XLEN-1:0]   rs2_rdata_o,
  output logic              commit_valid_o,
  output logic [XLEN-1:0]   commit_pc_o,
  output logic [ADDR_W-1:0] commit_rd_o,
  output logic [XLEN-1:0]   commit_wdata_o,
  output logic [XLEN-1:0]   instret_o
);

  // wb_valid_i qualifies every WB input for one cycle and cannot be back-pressured: each
  // high cycle retires exactly one instruction, and all other WB inputs are don't-care when low.

  logic [XLEN-1:0] regs [0:REG_NUM-1];
  logic [XLEN-1:0] instret_q;
  commit_rec_t     commit_q;
  logic            we;

  assign we = wb_valid_i & reg_wen_i & (rd_waddr_i != ZERO_ADDR);

  // Priority: x0 beats bypass, bypass beats the array; everything reads 0 while in reset.
  function automatic logic [XLEN-1:0] read_port(
    input logic              rst_l,
    input logic [ADDR_W-1:0] raddr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]   wdata,
    input logic [XLEN-1:0]   arr_data
  );
    logic [XLEN-1:0] res;
    res = arr_data;
    if (!rst_l || raddr == ZERO_ADDR) begin
      res = ZERO_WORD;
    end else if (wr_en && raddr == waddr) begin
      res = wdata;
    end
    return res;
  endfunction

  assign rs1_rdata_o = read_port(rst, rs1_raddr_i, we, rd_waddr_i, rd_wdata_i, regs[rs1_raddr_i]);
  assign rs2_rdata_o = read_port(rst, rs2_raddr_i, we, rd_waddr_i, rd_wdata_i, regs[rs2_raddr_i]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (we) begin
      regs[rd_waddr_i] <= rd_wdata_i;
    end
  end

  // Bubbles only drop the valid pulse; the rest of the record holds the last retirement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= ZERO_WORD;
      commit_q  <= '0;
    end else if (wb_valid_i) begin
      instret_q      <= instret_q + ONE_WORD;
      commit_q.valid <= 1'b1;
      commit_q.pc    <= inst_addr_i;
      commit_q.rd    <= we ? rd_waddr_i : ZERO_ADDR;
      commit_q.wdata <= we ? rd_wdata_i : ZERO_WORD;
    end else begin
      commit_q.valid <= 1'b0;
    end
  end

  assign commit_valid_o = commit_q.valid;
  assign commit_pc_o    = commit_q.pc;
  assign commit_rd_o    = commit_q.rd;
  assign commit_wdata_o = commit_q.wdata;
  assign instret_o      = instret_q;

endmodule
